vc_test_lfsr_delay_source: RTL and testbench
============================================

# vc_test_lfsr_delay_source

Test-harness message source that drives a val/rdy stream from a preloaded memory, inserting a pseudo-random number of idle cycles before each message. It is the transmitting end that pairs with `vc_TestRandDelaySink`. Delays come from an internal seeded LFSR rather than `$random`, so a failing stall pattern replays identically on every simulator and every run. It is bench-only and sits in the `vc` test library beside the existing source and sink.

## Interface
- `p_msg_nbits`, 8: message width.
- `p_num_msgs`, 1024: depth of message memory `m`.
- `p_seed`, 16'h0001: LFSR seed; a value of 0 is replaced by 1.
- `clk`  input  1  clock.
- `reset`  input  1  synchronous, active-high reset.
- `max_delay`  input  32  upper bound on idle cycles inserted before each message.
- `num_msgs`  input  32  number of valid memory entries; must be at most `p_num_msgs`.
- `val`  output  1  message valid.
- `rdy`  input  1  downstream ready.
- `msg`  output  `p_msg_nbits`  message payload.
- `done`  output  1  all `num_msgs` messages transferred.
- Memory `reg [p_msg_nbits-1:0] m[p_num_msgs-1:0]`, loaded hierarchically by the bench before reset deasserts.

## Operation
- **Registers:** `state` (RUN, DONE), `idx` (32b), `cnt` (32b delay counter), `lfsr` (16b).
- **LFSR:** 16-bit Galois, right shift, mask 16'hB400.
  - `next = lfsr[0] ? (lfsr>>1)^16'hB400 : lfsr>>1`.
  - Advances only on a transfer.
- **Delay draw:** `d(x) = {16'b0,x} % (max_delay+1)`, computed in 33 bits.
  - When `max_delay` = 32'hFFFFFFFF, `d(x) = x`.
  - `max_delay` is sampled only at a draw; changes mid-delay take effect at the next draw.
- **Reset (`reset`=1):**
  - `state`=RUN, `idx`=0, `lfsr`=seed, `cnt`=d(seed).
  - `val`=0 and `done`=0 regardless of the other registers.
- **RUN:**
  - If `idx`==`num_msgs`, go to DONE.
  - Else if `cnt`!=0, decrement `cnt`.
  - Else `val`=1.
  - On `val && rdy` (transfer): `idx` increments, `lfsr` takes `next`, and `cnt` is loaded with d(`next`).
- **DONE:** sticky until reset; `val`=0, `rdy` is ignored.
- **Outputs:**
  - `val` = RUN && `idx`<`num_msgs` && `cnt`==0 && !`reset`.
  - `msg` = `m[idx]` while `idx`<`num_msgs`, else 0.
  - `done` = (`state`==DONE) && !`reset`.
- **Protocol guarantee:** once `val` rises, `val` and `msg` stay constant until the transfer cycle. `val` never drops without a transfer.
- **Bounds:** `num_msgs`=0 means no `val` ever, and `done` rises one cycle after reset deasserts. Reading beyond `p_num_msgs` is a bench error, caught by an `$display` plus `$finish` check.
- **Line trace task `trace(inout trace_str)`:**
  - Prints `msg` in hex on a transfer.
  - Prints `#` when `val && !rdy`.
  - Prints blank when `!val`.
  - Every case is padded to `ceil(p_msg_nbits/4)` characters.

## Timing
- All state updates happen on `posedge clk`. `val`, `msg` and `done` are combinational from registers and `reset`.
- **Delay 0:** `val` is high in the first cycle after reset deasserts.
- **Back-to-back transfers:** one per cycle whenever every draw is 0 and `rdy` is held high.
- **Delay d:** `val` rises exactly d cycles after the transfer that drew it, or d cycles after reset deasserts for the first message.
- **Last message:** the transfer of message `num_msgs`-1 is followed by `done`=1 on the next cycle, independent of the drawn `cnt`.
- **Reset mid-stream:** the next cycle restarts from `idx`=0 with the seed delay. No partial transfer survives.
- **Simultaneous transfer and `max_delay` change:** the draw uses the new `max_delay` value present in that cycle.

## Test plan
- **Zero delay:** `max_delay`=0, sink delay 0, `num_msgs`=4 (8'h00,8'h01,8'h02,8'h03). Required: transfers on cycles 1–4 after reset; `done` on cycle 5; sink `num_failed`=0.
- **Seeded delay:** `max_delay`=2, `p_seed`=1. Required:
  - first draw 1%3=1, so `val` rises on cycle 2;
  - next draw 16'hB400%3=0, so message 1 transfers on the following cycle.
- **Backpressure:** `rdy` held low 5 cycles while `val`=1 with `msg`=8'hA5. Required: `val`/`msg` stable all 5 cycles; exactly one transfer; trace shows `#` five times.
- **Empty stream:** `num_msgs`=0. Required: `val` never high; `done`=1 one cycle after reset.
- **Mid-stream reset:** reset asserted after 2 of 4 transfers. Required: `val`=0 and `done`=0 during reset; the stream restarts at `m[0]`; the delay sequence is identical to the first run.
- **Pairing with sink:** paired with `vc_TestRandDelaySink`, source/sink delays (3,10), (10,3), (10,10), full ordered memory image. Required: `done` within 5000 cycles; `num_failed`=0.

Source files
------------

// File: rtl/vc_test_lfsr_delay_source.sv
//------------------------------------------------------------------------
// vc_test_lfsr_delay_source
//------------------------------------------------------------------------
// Test-harness message source. It streams messages from the preloaded
// memory m over a val/rdy interface. Before each message it inserts a
// pseudo-random number of idle cycles. The delays come from a seeded
// 16-bit Galois LFSR, so a stall pattern replays identically on every
// run. Bench-only companion to vc_TestRandDelaySink.
//
// Parameters:
//   p_msg_nbits  message width
//   p_num_msgs   depth of message memory m
//   p_seed       LFSR seed (a seed of 0 is replaced by 1)
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   max_delay  upper bound on idle cycles before each message
//   num_msgs   number of valid memory entries (at most p_num_msgs)
//   val        message valid
//   rdy        downstream ready
//   msg        message payload, m[idx] while idx < num_msgs, else 0
//   done       all num_msgs messages transferred
//
// The bench loads m hierarchically before reset deasserts.
//------------------------------------------------------------------------

`timescale 1ns/1ps

module vc_test_lfsr_delay_source
#(
    parameter int unsigned p_msg_nbits = 8,
    parameter int unsigned p_num_msgs  = 1024,
    parameter logic [15:0] p_seed      = 16'h0001
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            max_delay,
    input  logic [31:0]            num_msgs,
    output logic                   val,
    input  logic                   rdy,
    output logic [p_msg_nbits-1:0] msg,
    output logic                   done
);

    localparam logic [15:0] c_seed         = (p_seed == 16'h0000) ? 16'h0001 : p_seed;
    localparam logic [15:0] c_lfsr_mask    = 16'hB400;
    localparam int unsigned c_addr_nbits   = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1;
    localparam int unsigned c_trace_nchars = (p_msg_nbits + 3) / 4;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    // Message memory, written only by the bench
    logic [p_msg_nbits-1:0] m [p_num_msgs-1:0];

    state_t      state;
    state_t      state_next;
    logic [31:0] idx;
    logic [31:0] idx_next;
    logic [31:0] cnt;
    logic [31:0] cnt_next;
    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    logic [15:0] lfsr_step;
    logic        in_range;

    // Delay draw: x mod (max_delay + 1) in 33 bits, so max_delay of all
    // ones yields the LFSR value unchanged instead of dividing by zero.
    function automatic logic [31:0] draw(input logic [15:0] x,
                                         input logic [31:0] bound);
        logic [32:0] num;
        logic [32:0] den;
        num = {17'b0, x};
        den = {1'b0, bound} + 33'd1;
        return 32'(num % den);
    endfunction

    //--------------------------------------------------------------------
    // Combinational outputs
    //--------------------------------------------------------------------

    always_comb begin
        lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ c_lfsr_mask) : (lfsr >> 1);
        in_range  = (idx < num_msgs);
        val       = (state == RUN) && in_range && (cnt == '0) && !reset;
        done      = (state == DONE) && !reset;
    end

    // The extra bound against p_num_msgs keeps an oversized num_msgs
    // from reading outside the memory.
    always_comb begin
        msg = '0;
        if (in_range && (idx < 32'(p_num_msgs)))
            msg = m[idx[c_addr_nbits-1:0]];
    end

    //--------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------

    always_comb begin
        state_next = state;
        idx_next   = idx;
        cnt_next   = cnt;
        lfsr_next  = lfsr;
        case (state)
            RUN: begin
                if (!in_range) begin
                    state_next = DONE;
                end else if (cnt != '0) begin
                    cnt_next = cnt - 32'd1;
                end else if (rdy) begin
                    idx_next  = idx + 32'd1;
                    lfsr_next = lfsr_step;
                    cnt_next  = draw(lfsr_step, max_delay);
                    // Transferring the last message goes straight to DONE
                    // so done follows on the very next cycle.
                    if (idx_next == num_msgs)
                        state_next = DONE;
                end
            end
            DONE: begin
                state_next = DONE;
            end
        endcase
    end

    //--------------------------------------------------------------------
    // State registers
    //--------------------------------------------------------------------

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            idx   <= '0;
            lfsr  <= c_seed;
            cnt   <= draw(c_seed, max_delay);
        end else begin
            state <= state_next;
            idx   <= idx_next;
            lfsr  <= lfsr_next;
            cnt   <= cnt_next;
        end
    end

    //--------------------------------------------------------------------
    // Line trace: hex payload on a transfer, '#' when stalled by rdy,
    // blank when idle; each case padded to the hex width of msg.
    //--------------------------------------------------------------------

    task automatic trace(inout string trace_str);
        string s;
        if (val && rdy)
            s = $sformatf("%h", msg);
        else if (val)
            s = "#";
        else
            s = "";
        while (s.len() < int'(c_trace_nchars))
            s = {s, " "};
        trace_str = {trace_str, s};
    endtask

endmodule

// File: tb/tb_vc_test_lfsr_delay_source.sv
`timescale 1ns/1ps

module tb_vc_test_lfsr_delay_source;

    localparam int unsigned NUM_MSGS = 64;

    logic        clk;
    logic        reset;
    logic [31:0] max_delay;
    logic [31:0] num_msgs;
    logic        val;
    logic        rdy;
    logic [7:0]  msg;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    vc_test_lfsr_delay_source #(
        .p_msg_nbits (8),
        .p_num_msgs  (NUM_MSGS),
        .p_seed      (16'h0001)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .max_delay (max_delay),
        .num_msgs  (num_msgs),
        .val       (val),
        .rdy       (rdy),
        .msg       (msg),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs sampled 1ns later.
    task automatic next_cycle(input logic r);
        @(negedge clk);
        reset = 1'b0;
        rdy   = r;
        #1;
    endtask

    task automatic load_mem(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++)
            dut.m[i] = base + 8'(i);
    endtask

    task automatic do_reset(input logic [31:0] md, input logic [31:0] n);
        if (n > 32'(NUM_MSGS)) begin
            $display("FAIL num_msgs_bound: num_msgs=%0d exceeds depth %0d", n, NUM_MSGS);
            $fatal(1);
        end
        @(negedge clk);
        reset     = 1'b1;
        rdy       = 1'b0;
        max_delay = md;
        num_msgs  = n;
        @(negedge clk);
    endtask

    // Reset gating: with delay 0 val would be high without the reset term
    task automatic test_reset();
        load_mem(8'h00, 4);
        @(negedge clk);
        reset = 1'b1; rdy = 1'b1; max_delay = 32'd0; num_msgs = 32'd4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_vec++;
            if ({val, done} !== 2'b00) begin
                n_err++;
                $display("FAIL reset_gate c%0d: val,done=%b expected 00", i, {val, done});
            end
        end
        next_cycle(1'b1);
        n_vec++;
        if ({val, done, msg} !== {1'b1, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL reset_first_cycle: val,done,msg=%h expected %h", {val, done, msg}, {1'b1, 1'b0, 8'h00});
        end
    endtask

    task automatic test_zero_delay();
        logic [9:0] exp;
        load_mem(8'h00, 4);
        do_reset(32'd0, 32'd4);
        for (int k = 1; k <= 6; k++) begin
            next_cycle(1'b1);
            exp = (k <= 4) ? {1'b1, 1'b0, 8'(k - 1)} : {1'b0, 1'b1, 8'h00};
            n_vec++;
            if ({val, done, msg} !== exp) begin
                n_err++;
                $display("FAIL zero_delay c%0d: val,done,msg=%h expected %h", k, {val, done, msg}, exp);
            end
        end
    endtask

    // Seed 1, max_delay 2: draws 1%3=1, then B400,5A00,2D00 all %3=0
    task automatic run_seeded(input logic [7:0] base, input string name);
        logic [9:0] exp [6];
        exp[0] = {1'b0, 1'b0, base};
        exp[1] = {1'b1, 1'b0, base};
        exp[2] = {1'b1, 1'b0, base + 8'd1};
        exp[3] = {1'b1, 1'b0, base + 8'd2};
        exp[4] = {1'b1, 1'b0, base + 8'd3};
        exp[5] = {1'b0, 1'b1, 8'h00};
        for (int k = 0; k < 6; k++) begin
            next_cycle(1'b1);
            n_vec++;
            if ({val, done, msg} !== exp[k]) begin
                n_err++;
                $display("FAIL %s c%0d: val,done,msg=%h expected %h", name, k + 1, {val, done, msg}, exp[k]);
            end
        end
    endtask

    task automatic test_seeded_delay();
        load_mem(8'h10, 4);
        do_reset(32'd2, 32'd4);
        run_seeded(8'h10, "seeded");
    endtask

    // max_delay all ones: d(x)=x; the single message ends the stream
    // even though the following draw is B400
    task automatic test_max_delay_all_ones();
        logic [9:0] exp [4];
        exp[0] = {1'b0, 1'b0, 8'h40};
        exp[1] = {1'b1, 1'b0, 8'h40};
        exp[2] = {1'b0, 1'b1, 8'h00};
        exp[3] = {1'b0, 1'b1, 8'h00};
        load_mem(8'h40, 1);
        do_reset(32'hFFFF_FFFF, 32'd1);
        for (int k = 0; k < 4; k++) begin
            next_cycle(1'b1);
            n_vec++;
            if ({val, done, msg} !== exp[k]) begin
                n_err++;
                $display("FAIL max_ones c%0d: val,done,msg=%h expected %h", k + 1, {val, done, msg}, exp[k]);
            end
        end
    endtask

    // max_delay raised to 6 in the transfer cycle: draw B400%7=6.
    // Dropping it to 0 mid-delay must not shorten that delay.
    task automatic test_delay_change();
        logic [9:0] exp;
        load_mem(8'h30, 3);
        do_reset(32'd0, 32'd3);
        for (int k = 1; k <= 10; k++) begin
            next_cycle(1'b1);
            if (k == 1) max_delay = 32'd6;
            if (k == 2) max_delay = 32'd0;
            if (k == 1)       exp = {1'b1, 1'b0, 8'h30};
            else if (k <= 7)  exp = {1'b0, 1'b0, 8'h31};
            else if (k == 8)  exp = {1'b1, 1'b0, 8'h31};
            else if (k == 9)  exp = {1'b1, 1'b0, 8'h32};
            else              exp = {1'b0, 1'b1, 8'h00};
            n_vec++;
            if ({val, done, msg} !== exp) begin
                n_err++;
                $display("FAIL delay_change c%0d: val,done,msg=%h expected %h", k, {val, done, msg}, exp);
            end
        end
    endtask

    task automatic test_backpressure();
        string tstr;
        logic [9:0] exp;
        tstr = "";
        dut.m[0] = 8'hA5;
        dut.m[1] = 8'h5A;
        do_reset(32'd0, 32'd2);
        for (int k = 1; k <= 8; k++) begin
            next_cycle(k >= 6);
            if (k <= 6)       exp = {1'b1, 1'b0, 8'hA5};
            else if (k == 7)  exp = {1'b1, 1'b0, 8'h5A};
            else              exp = {1'b0, 1'b1, 8'h00};
            n_vec++;
            if ({val, done, msg} !== exp) begin
                n_err++;
                $display("FAIL backpressure c%0d: val,done,msg=%h expected %h", k, {val, done, msg}, exp);
            end
            dut.trace(tstr);
        end
        n_vec++;
        if (tstr != "# # # # # a55a  ") begin
            n_err++;
            $display("FAIL trace: got \"%s\" expected \"# # # # # a55a  \"", tstr);
        end
    endtask

    task automatic test_empty();
        logic [9:0] exp;
        do_reset(32'd0, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            next_cycle(1'b1);
            exp = (k == 1) ? 10'h000 : {1'b0, 1'b1, 8'h00};
            n_vec++;
            if ({val, done, msg} !== exp) begin
                n_err++;
                $display("FAIL empty c%0d: val,done,msg=%h expected %h", k, {val, done, msg}, exp);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_vec++;
        if ({val, done} !== 2'b00) begin
            n_err++;
            $display("FAIL empty_reset_done: val,done=%b expected 00", {val, done});
        end
    endtask

    task automatic test_mid_reset();
        load_mem(8'h20, 4);
        do_reset(32'd2, 32'd4);
        for (int k = 1; k <= 3; k++)
            next_cycle(1'b1);
        n_vec++;
        if ({val, msg} !== {1'b1, 8'h21}) begin
            n_err++;
            $display("FAIL mid_before: val,msg=%h expected %h", {val, msg}, {1'b1, 8'h21});
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            reset = 1'b1;
            rdy   = 1'b1;
            #1;
            n_vec++;
            if ({val, done} !== 2'b00) begin
                n_err++;
                $display("FAIL mid_reset_gate c%0d: val,done=%b expected 00", k, {val, done});
            end
        end
        run_seeded(8'h20, "mid_restart");
    endtask

    // Source paired with a randomly stalling sink; scoreboard on order,
    // plus stability of val/msg across every stall.
    task automatic test_pairing(input logic [31:0] src_d, input int snk_d);
        int         sink_wait;
        int         exp_idx;
        int         cyc;
        logic       stalled;
        logic [7:0] held_msg;
        exp_idx   = 0;
        stalled   = 1'b0;
        held_msg  = '0;
        sink_wait = $urandom_range(0, snk_d);
        load_mem(8'h00, NUM_MSGS);
        do_reset(src_d, 32'(NUM_MSGS));
        for (cyc = 0; cyc < 5000 && done !== 1'b1; cyc++) begin
            next_cycle(sink_wait == 0);
            if (stalled) begin
                n_vec++;
                if ({val, msg} !== {1'b1, held_msg}) begin
                    n_err++;
                    $display("FAIL pair_stall(%0d,%0d): val,msg=%h expected %h", src_d, snk_d, {val, msg}, {1'b1, held_msg});
                end
            end
            stalled  = val && !rdy;
            held_msg = msg;
            if (val && rdy) begin
                n_vec++;
                if (msg !== 8'(exp_idx)) begin
                    n_err++;
                    $display("FAIL pair_msg(%0d,%0d) #%0d: msg=%h expected %h", src_d, snk_d, exp_idx, msg, 8'(exp_idx));
                end
                exp_idx++;
                sink_wait = $urandom_range(0, snk_d);
            end else if (sink_wait > 0) begin
                sink_wait--;
            end
        end
        n_vec++;
        if (done !== 1'b1 || exp_idx != NUM_MSGS) begin
            n_err++;
            $display("FAIL pair_done(%0d,%0d): done=%b transfers=%0d expected done=1 transfers=%0d", src_d, snk_d, done, exp_idx, NUM_MSGS);
        end
    endtask

    initial begin
        reset     = 1'b1;
        rdy       = 1'b0;
        max_delay = '0;
        num_msgs  = '0;
        test_reset();
        test_zero_delay();
        test_seeded_delay();
        test_max_delay_all_ones();
        test_delay_change();
        test_backpressure();
        test_empty();
        test_mid_reset();
        test_pairing(32'd3, 10);
        test_pairing(32'd10, 3);
        test_pairing(32'd10, 10);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
